// File: rtl/rand_range_sampler_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rand_range_sampler_pkg : state encoding and widths for rand_range_sampler |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package rand_range_sampler_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam int REJ_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FILL  = ST_FILL,
    S_CHECK = ST_CHECK,
    S_HOLD  = ST_HOLD
  } state_e;

endpackage : rand_range_sampler_pkg
`default_nettype wire

// File: rtl/rand_range_sampler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rand_range_sampler : LFSR bit collector with rejection sampling to [0,lim) |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module rand_range_sampler
  import rand_range_sampler_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_REJ = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 gen_en_i,
  input  logic                 rand_i,
  input  logic [WIDTH-1:0]     limit_i,
  output logic                 lfsr_en_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     out_data_o,
  output logic [REJ_CNT_W-1:0] rej_cnt_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     word_q, word_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [REJ_CNT_W-1:0] rej_q, rej_d;
  logic [WIDTH-1:0]     lim_q, lim_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 lfsr_en;
  logic [WIDTH-1:0]     diff;

  // Only used on the fallback path, where word_q >= lim_q, so no underflow.
  assign diff = word_q - lim_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      bit_cnt_q <= '0;
      rej_q     <= '0;
      lim_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      bit_cnt_q <= bit_cnt_d;
      rej_q     <= rej_d;
      lim_q     <= lim_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    bit_cnt_d = bit_cnt_q;
    rej_d     = rej_q;
    lim_d     = lim_q;
    data_d    = data_q;
    valid_d   = valid_q;
    lfsr_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gen_en_i) begin
          state_d   = S_FILL;
          bit_cnt_d = '0;
          rej_d     = '0;
          lim_d     = limit_i;
        end
      end
      S_FILL: begin
        lfsr_en   = 1'b1;
        word_d    = {word_q[WIDTH-2:0], rand_i};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((lim_q == '0) || (word_q < lim_q)) begin
          data_d  = word_q;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else if (rej_q < REJ_CNT_W'(MAX_REJ)) begin
          rej_d     = (rej_q == {REJ_CNT_W{1'b1}}) ? rej_q : rej_q + 1'b1;
          bit_cnt_d = '0;
          state_d   = S_FILL;
        end else begin
          data_d  = (diff < lim_q) ? diff : '0;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready_i) begin
          valid_d = 1'b0;
          if (gen_en_i) begin
            state_d   = S_FILL;
            bit_cnt_d = '0;
            rej_d     = '0;
            lim_d     = limit_i;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign lfsr_en_o   = lfsr_en;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign rej_cnt_o   = rej_q;

endmodule : rand_range_sampler
`default_nettype wire
